// File: rtl/apb_pkg.sv
// apb_pkg: shared types, widths and the address-legality check for the
// APB wait-state completer (apb_wait_slave) and its wait counter.
//   apb_state_e   : completer FSM states (IDLE, ACCESS)
//   APB_ADDR_W/APB_DATA_W : APB bus widths
//   ID_REG_IDX    : word index of the read-only ID register
//   apb_addr_err(): flags misaligned, out-of-range, or ID-register writes
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned ID_REG_IDX = 0;

  // True when the byte address cannot be served: not word aligned, word
  // index beyond the register file, or a write aimed at the ID register.
  function automatic logic apb_addr_err(input logic [APB_ADDR_W-1:0] addr,
                                        input logic                  wr,
                                        input int unsigned           num_regs);
    logic [APB_ADDR_W-3:0] idx;
    idx = addr[APB_ADDR_W-1:2];
    return (addr[1:0] != 2'b00) ||
           ({2'b00, idx} >= num_regs) ||
           (wr && (idx == (APB_ADDR_W-2)'(ID_REG_IDX)));
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// apb_wait_counter: load/decrement down-counter that times the wait states
// of one APB access.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : synchronous active-high reset, count -> 0
//   load_i  : load WAIT_CYCLES (has priority over dec_i)
//   dec_i   : decrement by one while non-zero
//   done_o  : count == 0
module apb_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  // At least one bit so a zero-wait build still has a legal vector.
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(WAIT_CYCLES);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB3 completer with NUM_REGS 32-bit registers (index 0 is
// a read-only ID register returning ID_VALUE). Every access is stretched by
// WAIT_CYCLES wait states; illegal accesses complete with pslverr=1.
// Ports:
//   pclk, preset        : clock, synchronous active-high reset
//   pselx, penable      : APB select / enable phase
//   pwrite, paddr       : direction and byte address (captured at setup)
//   pwdata              : write data, sampled on the completion edge
//   pstrb               : byte strobes (only with APB_PSTRB_EN defined)
//   prdata              : read data, non-zero only while pready on a good read
//   pready, pslverr     : completion and error response
// Build option: define APB_PSTRB_EN to add APB4 byte strobes.
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int unsigned          NUM_REGS    = 8,
  parameter int unsigned          WAIT_CYCLES = 3,
  parameter logic [APB_DATA_W-1:0] ID_VALUE   = 32'hA5B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
`ifdef APB_PSTRB_EN
  input  logic [3:0]            pstrb,
`endif
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic             err_q;

  logic             capture;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_done;
  logic             wr_en;
  logic             ready_c;
  logic             setup_err;
  logic [3:0]       wstrb;
  logic [APB_DATA_W-1:0] rd_word;

  // Register 0 is the constant ID, so storage covers indices 1..NUM_REGS-1.
  logic [APB_DATA_W-1:0] regs_q [1:NUM_REGS-1];

`ifdef APB_PSTRB_EN
  assign wstrb     = pstrb;
  assign setup_err = apb_addr_err(paddr, pwrite, NUM_REGS) ||
                     (!pwrite && (pstrb != 4'b0000));
`else
  assign wstrb     = 4'b1111;
  assign setup_err = apb_addr_err(paddr, pwrite, NUM_REGS);
`endif

  apb_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk_i  (pclk),
    .rst_i  (preset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .done_o (cnt_done)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    wr_en    = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pselx && !penable) begin
          state_d  = ACCESS;
          capture  = 1'b1;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          // Requester abandoned the transfer: drop it without side effects.
          state_d = IDLE;
        end else begin
          ready_c = cnt_done;
          if (!cnt_done) begin
            cnt_dec = 1'b1;
          end else if (penable) begin
            state_d = IDLE;
            wr_en   = write_q && !err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (capture) begin
      idx_q   <= paddr[IDX_W+1:2];
      write_q <= pwrite;
      err_q   <= setup_err;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
              regs_q[i][8*b +: 8] <= pwdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (idx_q == IDX_W'(ID_REG_IDX)) begin
      rd_word = ID_VALUE;
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  assign pready  = ready_c;
  assign pslverr = ready_c && err_q;
  assign prdata  = (ready_c && !write_q && !err_q) ? rd_word : '0;

endmodule
